uart_rx_unit: RTL

Serial receiver that converts the 8N1 UART line from the opponent's board into byte-wide data and a one-cycle strobe. It sits directly upstream of the multiplayer message decoder: `dout` drives its character input and `rx_done_tick` drives its receive strobe. The block integrates the 16x oversampling tick generator, input synchronizer and framing-error detection, so the top level only routes the RX pin in.

---
 rtl/uart_rx_unit_if.sv | 24 ++
 rtl/uart_rx_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_unit_if.sv
// uart_rx_unit_if: serial line in, received byte and status pulses out.
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_unit_if #(
   parameter int DBIT = 8
);
   logic            rx;
   logic            rx_done_tick;
   logic [DBIT-1:0] dout;
   logic            frame_err;

   modport master (
      input  rx,
      output rx_done_tick,
      output dout,
      output frame_err
   );

   modport slave (
      output rx,
      input  rx_done_tick,
      input  dout,
      input  frame_err
   );
endinterface

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver with 16x oversampling, input
// synchronizer, built-in tick generator and framing-error detection.
module uart_rx_unit #(
   parameter int DVSR    = 54,
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input logic            clk,
   input logic            rst,
   uart_rx_unit_if.master bus
);

   localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [TW-1:0] T_LAST = TW'(DVSR - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic [3:0]    S_LAST = 4'(SB_TICK - 1);
   localparam logic [3:0]    S_MID  = 4'd7;
   localparam logic [3:0]    S_END  = 4'd15;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t          state;
   logic            sync_q;
   logic            rx_s;
   logic [TW-1:0]   tick_cnt;
   logic            s_tick;
   logic [3:0]      s;
   logic [NW-1:0]   n;
   logic [DBIT-1:0] b;
   logic [DBIT-1:0] dout_q;
   logic            done_q;
   logic            ferr_q;

   // Two-flop synchronizer; resets high so reset never looks like a start.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_q <= bus.rx;
         rx_s   <= sync_q;
      end
   end

   // Free-running oversample divider; never realigned to start edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick_cnt == T_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign s_tick = (tick_cnt == T_LAST);

   // Frame FSM with registered byte and one-clk status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         s      <= '0;
         n      <= '0;
         b      <= '0;
         dout_q <= '0;
         done_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s == S_MID) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s == S_END) begin
                     s <= '0;
                     b <= {rx_s, b[DBIT-1:1]};
                     if (n == N_LAST) begin
                        state <= STOP;
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (s == S_LAST) begin
                     if (rx_s) begin
                        dout_q <= b;
                        done_q <= 1'b1;
                        state  <= IDLE;
                     end else begin
                        ferr_q <= 1'b1;
                        state  <= WAIT_HIGH;
                     end
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
            WAIT_HIGH: begin
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.dout         = dout_q;
   assign bus.rx_done_tick = done_q;
   assign bus.frame_err    = ferr_q;

endmodule
